// File: rtl/rng_pkg.sv
// Shared RNG definitions: word width, LFSR taps, next-state law and checker states.
// Used by both the generator (random_mod) and rng_stream_checker so the two laws stay identical.
package rng_pkg;

  localparam int unsigned RNG_W = 16;

  // Taps at bits 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [RNG_W-1:0] RNG_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rng_chk_state_t;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [RNG_W-1:0] lfsr_next(input logic [RNG_W-1:0] x);
    return {x[RNG_W-2:0], ^(x & RNG_TAPS)};
  endfunction

endpackage

// File: rtl/rng_sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-high clear.
module rng_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count enabled increments, holding at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rng_stream_checker.sv
// Receive-side checker for the 16-bit LFSR stream: seeds a local predictor from the
// stream, locks after LOCK_CNT consecutive correct predictions, then flywheels and
// flags/counts mismatches. Optional sticky all-zero detector under RNG_CHK_STUCK_EN.
module rng_stream_checker
  import rng_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [RNG_W-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [RNG_W-1:0] err_count
`ifdef RNG_CHK_STUCK_EN
  ,
  output logic             stuck
`endif
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  rng_chk_state_t   state_q, state_d;
  logic [RNG_W-1:0] pred_q, pred_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q;
  logic             err_pulse_q, err_pulse_d;
  logic             err_inc;

  // Next-state: only accepted words move the FSM; bubbles hold everything
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (in_data != '0) begin
            pred_d  = lfsr_next(in_data);
            match_d = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (in_data == pred_q) begin
            pred_d = lfsr_next(in_data);
            if (match_q + 4'd1 == LOCK_C) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else if (in_data != '0) begin
            pred_d  = lfsr_next(in_data);
            match_d = '0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          pred_d = lfsr_next(pred_q);
          if (in_data == pred_q) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_q + 4'd1;
            // Losing lock reseeds from the offending word instead of flywheeling
            if (miss_q + 4'd1 == UNLOCK_C) begin
              state_d = ST_VERIFY;
              pred_d  = lfsr_next(in_data);
              match_d = '0;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // State and registered outputs; reset discards the word presented that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      pred_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= err_pulse_d;
    end
  end

  rng_sat_counter #(
    .W(RNG_W)
  ) u_err_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (err_inc),
    .count_o(err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

`ifdef RNG_CHK_STUCK_EN
  logic stuck_q;

  // Sticky flag for any accepted all-zero word, in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_q <= 1'b0;
    end else if (in_valid && (in_data == '0)) begin
      stuck_q <= 1'b1;
    end
  end

  assign stuck = stuck_q;
`endif

endmodule
